lsu_mem_if: RTL and testbench
=============================

LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 Parameter ADDR_W, default 32: width of lsu_addr and mem_addr.
REQ-002 Parameter TIMEOUT, default 255: max cycles in REQ+WAIT before abort; 0 disables the timeout.
REQ-003 Ports (name direction width meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  lsu_valid  in  1  upstream request valid.
  lsu_ready  out  1  unit can accept a request.
  lsu_we  in  1  1 = store, 0 = load.
  lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
  lsu_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
  lsu_addr  in  ADDR_W  byte address.
  lsu_wdata  in  32  store data, right-aligned.
  rsp_valid  out  1  one-cycle completion pulse.
  rsp_rdata  out  32  extended load data; 0 for stores and errors.
  rsp_err  out  1  misaligned, illegal size or timeout; valid with rsp_valid.
  mem_req  out  1  memory request.
  mem_we  out  1  memory write.
  mem_be  out  4  byte enables.
  mem_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
  mem_wdata  out  32  lane-replicated store data.
  mem_gnt  in  1  memory accepted request.
  mem_rvalid  in  1  memory completion; carries load data, acknowledges stores.
  mem_rdata  in  32  load word.

Function
REQ-004 FSM states IDLE, REQ, WAIT, RESP; lsu_ready = 1 only in IDLE and rst low.
REQ-005 Accept on lsu_valid & lsu_ready at an edge; latch we, size, unsigned, addr[1:0], mem fields.
REQ-006 Misalignment check at accept:
  - size 01 with addr[0]=1 is an error.
  - size 10 with addr[1:0]!=0 is an error.
  - size 11 is an error.
  On error go directly to RESP: rsp_err=1, rsp_rdata=0, mem_req never asserted.
REQ-007 Legal request goes to REQ: mem_req=1, with mem_we/mem_be/mem_addr/mem_wdata held stable until the edge where mem_gnt=1.
REQ-008 REQ exit:
  - mem_gnt & mem_rvalid -> RESP.
  - mem_gnt alone -> WAIT, with mem_req=0.
REQ-009 WAIT exits to RESP on mem_rvalid; mem_rdata is captured at that edge.
REQ-010 RESP lasts exactly one cycle with rsp_valid=1, then returns to IDLE; back-to-back accept is possible the cycle after RESP.
REQ-011 Minimum latency: accept at edge k, mem_req high in cycle k+1, gnt+rvalid in k+1, rsp_valid in cycle k+2.
REQ-012 Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
  mem_be has the same value for loads.
REQ-013 mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
REQ-014 Load extract:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits by sign (bit 7/15) or zero per lsu_unsigned.
  - Word loads pass through unchanged.
REQ-015 Store completion: rsp_rdata=0, rsp_err=0.
REQ-016 Timeout: the counter clears on accept and increments each cycle in REQ or WAIT. When TIMEOUT≠0 and count reaches TIMEOUT:
  - drop mem_req;
  - go to RESP with rsp_err=1, rsp_rdata=0.
  - A later stray mem_rvalid is ignored.
REQ-017 mem_gnt/mem_rvalid in IDLE or RESP are ignored; mem_rvalid in REQ without mem_gnt is ignored.
REQ-018 All outputs except lsu_ready are registered.

Reset
REQ-019 With rst high at an edge:
  - state becomes IDLE and the counter clears;
  - mem_req, mem_we, rsp_valid, rsp_err = 0;
  - mem_be, mem_addr, mem_wdata, rsp_rdata = 0;
  - lsu_ready = 0 while rst is high.
REQ-020 Reset during REQ/WAIT abandons the transaction with no rsp_valid; mem_req is 0 from the next cycle.

Verification
REQ-021 Byte load: addr 0x103, signed, mem_rdata 0x80AA_BBCC, gnt+rvalid same cycle -> mem_be 4'b1000, mem_addr 0x100, rsp_rdata 0xFFFF_FF80 two cycles after accept.
REQ-022 Half store: addr 0x202, wdata 0x1234_5678, gnt delayed 3 cycles, rvalid 2 cycles later -> mem_wdata 0x5678_5678, mem_be 4'b1100, fields stable while waiting, rsp_err 0.
REQ-023 Misaligned word load: addr 0x301 -> no mem_req, rsp_valid next cycle, rsp_err 1, rsp_rdata 0.
REQ-024 Timeout: TIMEOUT=4, mem_gnt held 0 -> mem_req drops after 4 cycles, rsp_err 1; a later mem_rvalid produces no rsp_valid.
REQ-025 Unsigned half load: addr 0x006, mem_rdata 0xF00D_0000 -> rsp_rdata 0x0000_F00D. Then rst asserted in WAIT of the next load -> mem_req=0 and no rsp_valid; lsu_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/lsu_mem_if_if.sv
// lsu_mem_if_if: bundles the LSU request/response handshake and the memory
// bus of lsu_mem_if into one interface.
//   slave  : view of the load/store unit (accepts LSU requests, drives memory)
//   master : view of the environment (issues LSU requests, plays the memory)
interface lsu_mem_if_if #(
   parameter int ADDR_W = 32
);
   // upstream request
   logic              lsu_valid;
   logic              lsu_ready;
   logic              lsu_we;
   logic [1:0]        lsu_size;
   logic              lsu_unsigned;
   logic [ADDR_W-1:0] lsu_addr;
   logic [31:0]       lsu_wdata;
   // completion
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport slave (
      input  lsu_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      output lsu_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output lsu_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      input  lsu_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: single-outstanding load/store unit front end. Takes one LSU
// request at a time, checks alignment, issues a lane-replicated word access
// with byte enables to memory, extracts/extends load data and returns a
// one-cycle completion. Transactions stuck in REQ/WAIT are aborted after
// TIMEOUT cycles (0 disables the timeout).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : lsu_mem_if_if.slave (LSU request/response + memory bus)
// All bus outputs are registered except lsu_ready.
module lsu_mem_if #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   lsu_mem_if_if.slave  bus
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   // request attributes needed after accept to shape the response
   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       uns;
      logic [1:0] off;
   } req_t;

   state_t        state;
   req_t          rq;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          tmo;
   logic          mis;
   logic [3:0]    be_nx;
   logic [31:0]   wd_nx;
   logic [31:0]   ld_sh;
   logic [15:0]   ld_h;
   logic [31:0]   ld_ext;

   assign bus.lsu_ready = (state == IDLE) && !rst;

   // request decode on the incoming LSU fields
   always_comb begin
      mis   = 1'b0;
      be_nx = 4'b1111;
      wd_nx = bus.lsu_wdata;
      case (bus.lsu_size)
         2'b00: begin
            be_nx = 4'b0001 << bus.lsu_addr[1:0];
            wd_nx = {4{bus.lsu_wdata[7:0]}};
         end
         2'b01: begin
            mis   = bus.lsu_addr[0];
            be_nx = 4'b0011 << {bus.lsu_addr[1], 1'b0};
            wd_nx = {2{bus.lsu_wdata[15:0]}};
         end
         2'b10:   mis = |bus.lsu_addr[1:0];
         default: mis = 1'b1;
      endcase
   end

   // load lane extraction from the returning memory word
   always_comb begin
      ld_sh  = bus.mem_rdata >> {rq.off, 3'b000};
      ld_h   = rq.off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (rq.size)
         2'b00:   ld_ext = {{24{~rq.uns & ld_sh[7]}}, ld_sh[7:0]};
         2'b01:   ld_ext = {{16{~rq.uns & ld_h[15]}}, ld_h};
         default: ld_ext = bus.mem_rdata;
      endcase
   end

   assign cnt_nx = cnt + 1'b1;
   assign tmo    = (TIMEOUT != 0) && (cnt_nx == TO_V);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rq            <= '0;
         cnt           <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.lsu_valid) begin
                  rq  <= '{we: bus.lsu_we, size: bus.lsu_size,
                           uns: bus.lsu_unsigned, off: bus.lsu_addr[1:0]};
                  cnt <= '0;
                  if (mis) begin
                     // bad request never reaches memory
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end else begin
                     state         <= REQ;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.lsu_we;
                     bus.mem_be    <= be_nx;
                     bus.mem_addr  <= {bus.lsu_addr[ADDR_W-1:2], 2'b00};
                     bus.mem_wdata <= wd_nx;
                  end
               end
            end
            REQ: begin
               cnt <= cnt_nx;
               // rvalid without gnt is not a completion
               if (bus.mem_gnt && bus.mem_rvalid) begin
                  bus.mem_req   <= 1'b0;
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= rq.we ? 32'h0 : ld_ext;
               end else if (tmo) begin
                  bus.mem_req   <= 1'b0;
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end else if (bus.mem_gnt) begin
                  bus.mem_req <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt_nx;
               if (bus.mem_rvalid) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= rq.we ? 32'h0 : ld_ext;
               end else if (tmo) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end
            end
            RESP: begin
               bus.rsp_valid <= 1'b0;
               bus.rsp_err   <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed checks of lsu_mem_if. Instance u_dut uses the
// default timeout; u_to uses TIMEOUT=4 for the abort case.
module tb_lsu_mem_if;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   lsu_mem_if_if #(.ADDR_W(32)) b ();
   lsu_mem_if_if #(.ADDR_W(32)) t ();

   lsu_mem_if #(.ADDR_W(32))              u_dut (.clk(clk), .rst(rst), .bus(b.slave));
   lsu_mem_if #(.ADDR_W(32), .TIMEOUT(4)) u_to  (.clk(clk), .rst(rst), .bus(t.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      b.lsu_valid    = 1'b1;
      b.lsu_we       = we;
      b.lsu_size     = size;
      b.lsu_unsigned = uns;
      b.lsu_addr     = addr;
      b.lsu_wdata    = wdata;
      tick();
      b.lsu_valid    = 1'b0;
   endtask

   // single-cycle gnt+rvalid load, checks be and extended data
   task automatic load1(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_d);
      issue(1'b0, size, uns, addr, 32'h0);
      chk({tag, "_be"}, {28'h0, b.mem_be}, {28'h0, exp_be});
      b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1; b.mem_rdata = rdata;
      tick();
      b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
      chk({tag, "_vld"}, {31'h0, b.rsp_valid}, 32'h1);
      chk({tag, "_data"}, b.rsp_rdata, exp_d);
      tick();
   endtask

   initial begin
      b.lsu_valid = 0; b.lsu_we = 0; b.lsu_size = 0; b.lsu_unsigned = 0;
      b.lsu_addr = 0; b.lsu_wdata = 0; b.mem_gnt = 0; b.mem_rvalid = 0; b.mem_rdata = 0;
      t.lsu_valid = 0; t.lsu_we = 0; t.lsu_size = 0; t.lsu_unsigned = 0;
      t.lsu_addr = 0; t.lsu_wdata = 0; t.mem_gnt = 0; t.mem_rvalid = 0; t.mem_rdata = 0;

      // reset state
      tick(); tick();
      chk("rst_ready", {31'h0, b.lsu_ready}, 32'h0);
      chk("rst_req",   {31'h0, b.mem_req}, 32'h0);
      chk("rst_vld",   {31'h0, b.rsp_valid}, 32'h0);
      chk("rst_be",    {28'h0, b.mem_be}, 32'h0);
      chk("rst_addr",  b.mem_addr, 32'h0);
      chk("rst_rdata", b.rsp_rdata, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'h0, b.lsu_ready}, 32'h1);

      // signed byte load, minimum latency
      b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h80AA_BBCC;
      issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      chk("bl_req",   {31'h0, b.mem_req}, 32'h1);
      chk("bl_be",    {28'h0, b.mem_be}, 32'h8);
      chk("bl_addr",  b.mem_addr, 32'h100);
      chk("bl_we",    {31'h0, b.mem_we}, 32'h0);
      chk("bl_ready", {31'h0, b.lsu_ready}, 32'h0);
      chk("bl_vld0",  {31'h0, b.rsp_valid}, 32'h0);
      tick();
      b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
      chk("bl_vld",   {31'h0, b.rsp_valid}, 32'h1);
      chk("bl_data",  b.rsp_rdata, 32'hFFFF_FF80);
      chk("bl_err",   {31'h0, b.rsp_err}, 32'h0);
      chk("bl_req_off", {31'h0, b.mem_req}, 32'h0);
      tick();
      chk("bl_vld_end", {31'h0, b.rsp_valid}, 32'h0);
      chk("bl_ready_end", {31'h0, b.lsu_ready}, 32'h1);

      // half store with delayed grant; stray rvalid in REQ ignored
      issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_5678);
      b.mem_rvalid = 1'b1; b.mem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) b.mem_gnt = 1'b1;
         chk("hs_req",   {31'h0, b.mem_req}, 32'h1);
         chk("hs_we",    {31'h0, b.mem_we}, 32'h1);
         chk("hs_wdata", b.mem_wdata, 32'h5678_5678);
         chk("hs_be",    {28'h0, b.mem_be}, 32'hC);
         chk("hs_addr",  b.mem_addr, 32'h200);
         chk("hs_vld0",  {31'h0, b.rsp_valid}, 32'h0);
         tick();
         b.mem_rvalid = 1'b0;
      end
      b.mem_gnt = 1'b0;
      chk("hs_wait_req", {31'h0, b.mem_req}, 32'h0);
      tick();
      chk("hs_wait_vld", {31'h0, b.rsp_valid}, 32'h0);
      b.mem_rvalid = 1'b1;
      tick();
      b.mem_rvalid = 1'b0;
      chk("hs_vld",  {31'h0, b.rsp_valid}, 32'h1);
      chk("hs_err",  {31'h0, b.rsp_err}, 32'h0);
      chk("hs_data", b.rsp_rdata, 32'h0);
      tick();

      // misaligned word and illegal size: immediate error, no memory access
      issue(1'b0, 2'b10, 1'b0, 32'h301, 32'h0);
      chk("mw_req",  {31'h0, b.mem_req}, 32'h0);
      chk("mw_vld",  {31'h0, b.rsp_valid}, 32'h1);
      chk("mw_err",  {31'h0, b.rsp_err}, 32'h1);
      chk("mw_data", b.rsp_rdata, 32'h0);
      tick();
      issue(1'b1, 2'b11, 1'b0, 32'h400, 32'hFFFF_FFFF);
      chk("sz3_req", {31'h0, b.mem_req}, 32'h0);
      chk("sz3_err", {31'h0, b.rsp_err}, 32'h1);
      tick();
      issue(1'b0, 2'b01, 1'b0, 32'h005, 32'h0);
      chk("mh_err",  {31'h0, b.rsp_err}, 32'h1);
      tick();

      // load extraction table
      load1("uh",  2'b01, 1'b1, 32'h006, 32'hF00D_0000, 4'hC, 32'h0000_F00D);
      load1("sh",  2'b01, 1'b0, 32'h002, 32'h8001_1234, 4'hC, 32'hFFFF_8001);
      load1("sh0", 2'b01, 1'b0, 32'h000, 32'h8001_1234, 4'h3, 32'h0000_1234);
      load1("ub",  2'b00, 1'b1, 32'h001, 32'h0000_AB00, 4'h2, 32'h0000_00AB);
      load1("sb",  2'b00, 1'b0, 32'h002, 32'h0081_0000, 4'h4, 32'hFFFF_FF81);
      load1("wd",  2'b10, 1'b0, 32'h00C, 32'h8765_4321, 4'hF, 32'h8765_4321);

      // reset while in WAIT abandons the load
      issue(1'b0, 2'b10, 1'b0, 32'h008, 32'h0);
      b.mem_gnt = 1'b1;
      tick();
      b.mem_gnt = 1'b0;
      chk("rw_wait_req", {31'h0, b.mem_req}, 32'h0);
      rst = 1'b1; b.mem_rvalid = 1'b1;
      tick();
      b.mem_rvalid = 1'b0;
      chk("rw_vld",   {31'h0, b.rsp_valid}, 32'h0);
      chk("rw_req",   {31'h0, b.mem_req}, 32'h0);
      chk("rw_ready", {31'h0, b.lsu_ready}, 32'h0);
      rst = 1'b0;
      tick();
      chk("rw_ready_after", {31'h0, b.lsu_ready}, 32'h1);
      chk("rw_vld_after",   {31'h0, b.rsp_valid}, 32'h0);

      // reset while in REQ drops mem_req next cycle
      issue(1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
      chk("rr_req", {31'h0, b.mem_req}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rr_req_off", {31'h0, b.mem_req}, 32'h0);
      chk("rr_vld",     {31'h0, b.rsp_valid}, 32'h0);
      tick();

      // timeout on the TIMEOUT=4 instance
      t.lsu_valid = 1'b1; t.lsu_size = 2'b10; t.lsu_addr = 32'h10;
      tick();
      t.lsu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_req",  {31'h0, t.mem_req}, 32'h1);
         chk("to_vld0", {31'h0, t.rsp_valid}, 32'h0);
         tick();
      end
      chk("to_req_off", {31'h0, t.mem_req}, 32'h0);
      chk("to_vld",     {31'h0, t.rsp_valid}, 32'h1);
      chk("to_err",     {31'h0, t.rsp_err}, 32'h1);
      chk("to_data",    t.rsp_rdata, 32'h0);
      tick();
      chk("to_vld_end", {31'h0, t.rsp_valid}, 32'h0);
      t.mem_rvalid = 1'b1; t.mem_rdata = 32'h1111_2222;
      tick();
      t.mem_rvalid = 1'b0;
      chk("to_stray", {31'h0, t.rsp_valid}, 32'h0);
      tick();
      chk("to_stray2", {31'h0, t.rsp_valid}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
